// File: rtl/line_matrix_cfg_seq.sv
// Hardware sequencer that programs the AD9361 GPO line matrix: it clears the matrix,
// then applies {input, output} route entries with a setup / clock-pulse / hold sequence.
module line_matrix_cfg_seq #(
    parameter int SEL_WIDTH    = 4,
    parameter int NUM_INPUTS   = 8,
    parameter int NUM_OUTPUTS  = 9,
    parameter int RST_CYCLES   = 4,
    parameter int SETUP_CYCLES = 2,
    parameter int HIGH_CYCLES  = 2,
    parameter int HOLD_CYCLES  = 1
) (
    input  logic                 sys_clk,
    input  logic                 rst,
    input  logic                 clear_req,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [SEL_WIDTH-1:0] cfg_in_sel,
    input  logic [SEL_WIDTH-1:0] cfg_out_sel,
    output logic                 busy,
    output logic [7:0]           route_cnt,
    output logic                 err_sticky,
    input  logic                 err_clr,
    output logic                 lm_clk_pin,
    output logic                 lm_rstn,
    output logic [SEL_WIDTH-1:0] lm_input_select,
    output logic [SEL_WIDTH-1:0] lm_output_select
);

    localparam int MAX_AB   = (RST_CYCLES > SETUP_CYCLES) ? RST_CYCLES : SETUP_CYCLES;
    localparam int MAX_CD   = (HIGH_CYCLES > HOLD_CYCLES) ? HIGH_CYCLES : HOLD_CYCLES;
    localparam int MAX_CYC  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CNT_W    = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] RST_LOAD   = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] HIGH_LOAD  = CNT_W'(HIGH_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYCLES - 1);

    localparam logic [SEL_WIDTH:0] IN_LIMIT  = (SEL_WIDTH+1)'(NUM_INPUTS);
    localparam logic [SEL_WIDTH:0] OUT_LIMIT = (SEL_WIDTH+1)'(NUM_OUTPUTS);

    typedef enum logic [2:0] {
        CLEAR  = 3'd0,
        IDLE   = 3'd1,
        SETUP  = 3'd2,
        CLK_HI = 3'd3,
        HOLD   = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 clearPend_q, clearPend_d;
    logic [SEL_WIDTH-1:0] inSel_q, inSel_d;
    logic [SEL_WIDTH-1:0] outSel_q, outSel_d;
    logic [7:0]           routeCnt_q, routeCnt_d;
    logic                 errSticky_q, errSticky_d;
    logic                 clkPin_q, clkPin_d;
    logic                 rstn_q, rstn_d;

    logic cntDone;
    logic clearAny;
    logic fire;
    logic entryOk;
    logic readyInt;

    assign cntDone  = (cnt_q == '0);
    assign clearAny = clear_req | clearPend_q;
    assign readyInt = (state_q == IDLE) & ~clear_req & ~clearPend_q;
    assign fire     = cfg_valid & readyInt;
    assign entryOk  = ({1'b0, cfg_in_sel} < IN_LIMIT) & ({1'b0, cfg_out_sel} < OUT_LIMIT);

    // State register; reset lands in CLEAR so the matrix is always reset after power-up.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q <= CLEAR;
            cnt_q   <= RST_LOAD;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cntDone ? cnt_q : cnt_q - 1'b1;
        unique case (state_q)
            CLEAR: begin
                if (cntDone) begin
                    if (clearAny) begin
                        state_d = CLEAR;
                        cnt_d   = RST_LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            IDLE: begin
                if (clearAny) begin
                    state_d = CLEAR;
                    cnt_d   = RST_LOAD;
                end else if (fire && entryOk) begin
                    state_d = SETUP;
                    cnt_d   = SETUP_LOAD;
                end
            end
            SETUP: begin
                if (cntDone) begin
                    state_d = CLK_HI;
                    cnt_d   = HIGH_LOAD;
                end
            end
            CLK_HI: begin
                if (cntDone) begin
                    state_d = HOLD;
                    cnt_d   = HOLD_LOAD;
                end
            end
            HOLD: begin
                // A clear that arrived during the write starts straight after the hold.
                if (cntDone) begin
                    if (clearAny) begin
                        state_d = CLEAR;
                        cnt_d   = RST_LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = CLEAR;
                cnt_d   = RST_LOAD;
            end
        endcase
    end

    always_comb begin
        busy             = (state_q != IDLE);
        cfg_ready        = readyInt;
        lm_clk_pin       = clkPin_q;
        lm_rstn          = rstn_q;
        lm_input_select  = inSel_q;
        lm_output_select = outSel_q;
        route_cnt        = routeCnt_q;
        err_sticky       = errSticky_q;
    end

    // Datapath next-state: pending clear, selects, counter, error flag and pin drivers.
    always_comb begin
        clearPend_d = clearAny;
        if ((state_d == CLEAR) && ((state_q != CLEAR) || cntDone)) begin
            clearPend_d = 1'b0;
        end

        inSel_d  = inSel_q;
        outSel_d = outSel_q;
        if ((state_q == IDLE) && (state_d == SETUP)) begin
            inSel_d  = cfg_in_sel;
            outSel_d = cfg_out_sel;
        end

        routeCnt_d = routeCnt_q;
        if ((state_q == CLEAR) && cntDone) begin
            routeCnt_d = 8'd0;
        end else if ((state_q == HOLD) && cntDone && (routeCnt_q != 8'hFF)) begin
            routeCnt_d = routeCnt_q + 8'd1;
        end

        errSticky_d = errSticky_q;
        if (fire && !entryOk) begin
            errSticky_d = 1'b1;
        end else if (err_clr) begin
            errSticky_d = 1'b0;
        end

        clkPin_d = (state_d == CLK_HI);
        rstn_d   = (state_d != CLEAR);
    end

    // Pin drivers are registered from the next state so they never glitch on decode.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            clearPend_q <= 1'b0;
            inSel_q     <= '0;
            outSel_q    <= '0;
            routeCnt_q  <= 8'd0;
            errSticky_q <= 1'b0;
            clkPin_q    <= 1'b0;
            rstn_q      <= 1'b0;
        end else begin
            clearPend_q <= clearPend_d;
            inSel_q     <= inSel_d;
            outSel_q    <= outSel_d;
            routeCnt_q  <= routeCnt_d;
            errSticky_q <= errSticky_d;
            clkPin_q    <= clkPin_d;
            rstn_q      <= rstn_d;
        end
    end

endmodule

// File: doc/line_matrix_cfg_seq.md
Name: line_matrix_cfg_seq

Overview:
- Hardware programmer for the line matrix that routes AD9361 RFIC GPO inputs to the RF-panel GPO outputs.
- Replaces software bit-banging of the matrix clk_pin, rstn and select pins over EMIO GPIO.
- Software or a PL master pushes {input, output} route entries through a valid/ready interface.
- The block sequences the matrix reset, select setup, clock pulse and hold with deterministic timing, and counts and validates each entry.

Parameters:
- SEL_WIDTH, 4, width of the matrix input/output select buses.
- NUM_INPUTS, 8, number of valid input lines; in_sel >= NUM_INPUTS is an error.
- NUM_OUTPUTS, 9, number of valid output lines; out_sel >= NUM_OUTPUTS is an error.
- RST_CYCLES, 4, cycles lm_rstn is held low during a clear.
- SETUP_CYCLES, 2, cycles the selects are stable before lm_clk_pin rises (min 1).
- HIGH_CYCLES, 2, cycles lm_clk_pin stays high (min 1).
- HOLD_CYCLES, 1, cycles the selects are held after lm_clk_pin falls (min 1).

Ports:
- sys_clk  in  1  block clock (ad_clk_ref domain)
- rst  in  1  asynchronous, active-high reset
- clear_req  in  1  single-cycle pulse; request a full matrix reset
- cfg_valid  in  1  route entry valid
- cfg_ready  out  1  route entry accepted when cfg_valid&cfg_ready
- cfg_in_sel  in  SEL_WIDTH  input line to route
- cfg_out_sel  in  SEL_WIDTH  output line to drive
- busy  out  1  high whenever state != IDLE
- route_cnt  out  8  successful writes since the last clear; saturates at 255
- err_sticky  out  1  set on a rejected entry
- err_clr  in  1  clears err_sticky
- lm_clk_pin  out  1  to matrix clk_pin
- lm_rstn  out  1  to matrix rstn
- lm_input_select  out  SEL_WIDTH  to matrix input_select
- lm_output_select  out  SEL_WIDTH  to matrix output_select

Behaviour:
- States: CLEAR, IDLE, SETUP, CLK_HI, HOLD.
- Reset values:
  - state=CLEAR, lm_rstn=0, lm_clk_pin=0.
  - Selects=0, route_cnt=0, err_sticky=0, cfg_ready=0, busy=1.
  - Reset asserted mid-operation aborts immediately to these values, including mid-pulse: lm_clk_pin falls asynchronously.
- CLEAR:
  - lm_rstn=0 for RST_CYCLES cycles, counted by a down-counter.
  - Then lm_rstn=1, route_cnt=0, go to IDLE.
- IDLE:
  - cfg_ready = (state==IDLE) & !clear_req & !clear_pend. cfg_ready is registered-state based plus the clear_req gate.
  - clear_req or clear_pend goes to CLEAR next cycle and clears clear_pend. This has priority over a simultaneous cfg_valid; that entry is not accepted.
- Accept at edge E0 with a valid entry:
  - lm_input_select and lm_output_select are registered at E0; state goes to SETUP.
  - lm_clk_pin rises at E0+SETUP_CYCLES and falls at E0+SETUP_CYCLES+HIGH_CYCLES (state HOLD).
  - Return to IDLE at E0+SETUP+HIGH+HOLD; route_cnt increments at that edge.
  - Defaults: pulse high over E2..E4, IDLE after E5, next accept earliest at E6 (6 cycles per write).
- Accept with an invalid entry (in_sel >= NUM_INPUTS or out_sel >= NUM_OUTPUTS):
  - Entry is consumed and err_sticky=1.
  - Selects are not updated and no clock pulse is issued.
  - Stay in IDLE; cfg_ready stays 1.
- Selects hold their last value outside writes and are never changed while lm_clk_pin=1 or in HOLD.
- clear_req while busy (SETUP/CLK_HI/HOLD/CLEAR):
  - Latched into clear_pend; the current write or clear completes first, then CLEAR runs.
  - Multiple pulses coalesce into one clear.
- err_sticky: set has priority over a simultaneous err_clr.
- route_cnt saturates at 255; it does not wrap.
- lm_rstn is 1 in every state except CLEAR; lm_clk_pin is 1 only in CLK_HI.

Test Plan:
- Reset release -> lm_rstn=0 for exactly 4 cycles then 1; cfg_ready rises the cycle after; route_cnt=0.
- Accept entry (3,7) at E0 -> selects 3/7 from E0; lm_clk_pin high only over E2..E4; route_cnt=1 at E5; cfg_ready=1 after E5; second entry accepted at E6 pulses at E8.
- Entry (2,12) -> no pulse, selects unchanged, err_sticky=1. Then err_clr+new error in the same cycle -> err_sticky stays 1. err_clr alone -> 0.
- clear_req at E1 during a write -> pulse completes at E4, IDLE skipped, lm_rstn=0 for 4 cycles from E5, route_cnt=0 afterwards.
- Simultaneous clear_req and cfg_valid in IDLE -> entry not accepted (cfg_ready=0), CLEAR runs; the entry is accepted after the clear.
- Async rst asserted mid-CLK_HI -> lm_clk_pin and lm_rstn drop to 0 without a clock edge; CLEAR re-runs after deassertion. Also: 260 valid writes -> route_cnt=255.
